// File: rtl/cdb_arbiter.sv
// cdb_arbiter: priority-class round-robin arbiter driving the single registered Common Data Bus.
// Define CDB_AGE_BOOST_EN to add per-FU wait counters that bound low-priority starvation.

`ifdef CDB_AGE_BOOST_EN
// Per-FU saturating wait counter; boost_o flags a requester that has waited MAX_WAIT cycles.
module cdb_wait_ctr #(
  parameter int MAX_WAIT = 8,
  parameter int CNT_W    = 4
) (
  input  logic clock_i,
  input  logic reset_i,
  input  logic clr_i,
  input  logic inc_i,
  output logic boost_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (inc_i && (cnt_q != CNT_W'(MAX_WAIT)))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign boost_o = (cnt_q == CNT_W'(MAX_WAIT));
endmodule
`endif

module cdb_arbiter #(
  parameter int NUM_FU   = 5,
  parameter int TAG_W    = 5,
  parameter int XLEN     = 32,
  parameter int MAX_WAIT = 8
) (
  input  logic                             clock_i,
  input  logic                             reset_i,
  input  logic                             squash_i,
  input  logic [NUM_FU-1:0]                done_i,
  input  logic [NUM_FU-1:0]                prio_i,
  input  logic [NUM_FU-1:0][TAG_W-1:0]     fu_tag_i,
  input  logic [NUM_FU-1:0][XLEN-1:0]      fu_value_i,
  output logic [NUM_FU-1:0]                ack_o,
  output logic                             cdb_valid_o,
  output logic [TAG_W-1:0]                 cdb_tag_o,
  output logic [XLEN-1:0]                  cdb_value_o,
  output logic [((NUM_FU > 1) ? $clog2(NUM_FU) : 1)-1:0] cdb_fu_idx_o
);
  localparam int IDX_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  value;
    logic [IDX_W-1:0] idx;
  } cdb_pkt_t;

  if (NUM_FU < 1 || MAX_WAIT < 1) begin : g_cfg_chk
    $error("cdb_arbiter: NUM_FU and MAX_WAIT must be at least 1");
  end

  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
  cdb_pkt_t          cdb_q, cdb_d;
  logic [NUM_FU-1:0] hi_req, cand;
  logic [IDX_W-1:0]  win_idx;
  logic              win_vld;
  logic              grant_en;

`ifdef CDB_AGE_BOOST_EN
  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  logic [NUM_FU-1:0] boost, boosted;

  for (genvar g = 0; g < NUM_FU; g++) begin : g_wait
    cdb_wait_ctr #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) u_ctr (
      .clock_i (clock_i),
      .reset_i (reset_i),
      .clr_i   (squash_i | ~done_i[g] | ack_o[g]),
      .inc_i   (done_i[g] & ~ack_o[g]),
      .boost_o (boost[g])
    );
  end

  // A counter can still read MAX_WAIT the cycle after done drops, so gate with done.
  assign boosted = boost & done_i;
`endif

  always_comb begin
    hi_req = done_i & prio_i;
    cand   = (|hi_req) ? hi_req : done_i;
`ifdef CDB_AGE_BOOST_EN
    if (|boosted) cand = boosted;
`endif
  end

  // First candidate at or after rr_ptr, wrapping modulo NUM_FU.
  always_comb begin : rr_pick
    int idx;
    idx     = 0;
    win_vld = 1'b0;
    win_idx = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NUM_FU) idx = idx - NUM_FU;
      if (!win_vld && cand[idx]) begin
        win_vld = 1'b1;
        win_idx = IDX_W'(idx);
      end
    end
  end

  assign grant_en = win_vld && !squash_i && !reset_i;
  assign ack_o    = grant_en ? (NUM_FU'(1) << win_idx) : '0;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (grant_en)
      rr_ptr_d = (win_idx == IDX_W'(NUM_FU - 1)) ? '0 : win_idx + 1'b1;
  end

  // Tag/value/idx hold their last broadcast when nothing is granted.
  always_comb begin
    cdb_d       = cdb_q;
    cdb_d.valid = grant_en;
    if (grant_en) begin
      cdb_d.tag   = fu_tag_i[win_idx];
      cdb_d.value = fu_value_i[win_idx];
      cdb_d.idx   = win_idx;
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      rr_ptr_q <= '0;
      cdb_q    <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      cdb_q    <= cdb_d;
    end
  end

  assign cdb_valid_o  = cdb_q.valid;
  assign cdb_tag_o    = cdb_q.tag;
  assign cdb_value_o  = cdb_q.value;
  assign cdb_fu_idx_o = cdb_q.idx;
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed scenarios plus randomized FU traffic against a rule-level CDB arbiter model.
module tb_cdb_arbiter;
  localparam int N  = 5;
  localparam int TW = 5;
  localparam int XW = 32;
  localparam int MW = 8;
  localparam int IW = 3;

  logic              clk = 1'b0;
  logic              rst, squash;
  logic [N-1:0]      done, prio, ack;
  logic [N-1:0][TW-1:0] tag;
  logic [N-1:0][XW-1:0] val;
  logic              cdb_valid;
  logic [TW-1:0]     cdb_tag;
  logic [XW-1:0]     cdb_value;
  logic [IW-1:0]     cdb_idx;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  bit            m_known = 1'b0;
  int            m_rr;
  logic          m_valid;
  logic [TW-1:0] m_tag;
  logic [XW-1:0] m_val;
  logic [IW-1:0] m_idx;
  int            m_cnt [N];
  logic [N-1:0]  m_ack;

  always #5 clk = ~clk;

  cdb_arbiter #(.NUM_FU(N), .TAG_W(TW), .XLEN(XW), .MAX_WAIT(MW)) dut (
    .clock_i      (clk),
    .reset_i      (rst),
    .squash_i     (squash),
    .done_i       (done),
    .prio_i       (prio),
    .fu_tag_i     (tag),
    .fu_value_i   (val),
    .ack_o        (ack),
    .cdb_valid_o  (cdb_valid),
    .cdb_tag_o    (cdb_tag),
    .cdb_value_o  (cdb_value),
    .cdb_fu_idx_o (cdb_idx)
  );

  task automatic chk(input string t, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", t, got, exp);
    end
  endtask

  function automatic logic [N-1:0] model_ack();
    logic [N-1:0] c;
    logic [N-1:0] b;
    if (rst || squash || done == '0) return '0;
    c = done & prio;
    if (c == '0) c = done;
`ifdef CDB_AGE_BOOST_EN
    b = '0;
    for (int i = 0; i < N; i++) if (done[i] && m_cnt[i] == MW) b[i] = 1'b1;
    if (b != '0) c = b;
`else
    b = '0;
`endif
    for (int k = 0; k < N; k++)
      if (c[(m_rr + k) % N]) return N'(1) << ((m_rr + k) % N);
    return b;
  endfunction

  // Check this cycle's outputs, then advance the model across the next posedge.
  task automatic step();
    #3;
    m_ack = model_ack();
    chk("ack", ack, m_ack);
    if (m_known) begin
      chk("cdb_valid", cdb_valid, m_valid);
      chk("cdb_tag", cdb_tag, m_tag);
      chk("cdb_value", cdb_value, m_val);
      chk("cdb_fu_idx", cdb_idx, m_idx);
    end
    @(posedge clk);
    #1;
    if (rst) begin
      m_known = 1'b1;
      m_rr = 0; m_valid = 1'b0; m_tag = '0; m_val = '0; m_idx = '0;
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
    end else begin
      m_valid = (m_ack != '0);
      for (int i = 0; i < N; i++) begin
        if (m_ack[i]) begin
          m_tag = tag[i]; m_val = val[i]; m_idx = IW'(i); m_rr = (i + 1) % N;
        end
        if (squash || !done[i] || m_ack[i]) m_cnt[i] = 0;
        else if (m_cnt[i] < MW)             m_cnt[i] = m_cnt[i] + 1;
      end
    end
  endtask

  initial begin
    int ord [5] = '{3, 4, 0, 1, 2};
    int fu0_at;
    rst = 1'b1; squash = 1'b0; done = '1; prio = '0;
    for (int i = 0; i < N; i++) begin tag[i] = TW'(i); val[i] = XW'(i * 16); end

    // 1: reset held two cycles with all done
    step(); step();
    rst = 1'b0;
    #2 chk("t1_first_ack", ack, 5'b00001);
    step();
    done = '0;
    step();

    // 2: single request
    done = 5'b00100; tag[2] = 5'd7; val[2] = 32'hDEAD_BEEF;
    #2 chk("t2_ack", ack, 5'b00100);
    step();
    done = '0;
    chk("t2_valid", cdb_valid, 1'b1);
    chk("t2_tag", cdb_tag, 5'd7);
    chk("t2_value", cdb_value, 32'hDEAD_BEEF);
    chk("t2_idx", cdb_idx, 3'd2);

    // 3: all five from rr_ptr=3, each dropped after its ack
    done = '1;
    for (int j = 0; j < 5; j++) begin
      #2 chk("t3_order", ack, N'(1) << ord[j]);
      step();
      done[ord[j]] = 1'b0;
      chk("t3_valid", cdb_valid, 1'b1);
    end
    step();

    // 4: FU2 high priority held against four low-priority requesters
    done = '1; prio = 5'b00100; fu0_at = -1;
    for (int c = 0; c < 20; c++) begin
      #2;
`ifdef CDB_AGE_BOOST_EN
      if (ack[0] && fu0_at < 0) fu0_at = c;
`else
      chk("t4_prio_only", ack, 5'b00100);
`endif
      step();
    end
`ifdef CDB_AGE_BOOST_EN
    chk("t4_boost_bound", (fu0_at >= 0) && (fu0_at <= MW + N), 1'b1);
`endif
    done = '0; prio = '0;
    step();

    // 5: squash blocks the grant in its own cycle only
    done = 5'b00010; squash = 1'b1;
    #2 chk("t5_squash_ack", ack, 5'b00000);
    step();
    squash = 1'b0;
    chk("t5_squash_valid", cdb_valid, 1'b0);
    #2 chk("t5_after_ack", ack, 5'b00010);
    step();
    done = '0;

    // 6: reset right after a grant
    done = 5'b10000;
    #2 chk("t6_ack", ack, 5'b10000);
    step();
    done = '0; rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6_valid", cdb_valid, 1'b0);
    done = '1;
    #2 chk("t6_rr_reset", ack, 5'b00001);
    step();
    done = '0;
    step();

    // Randomized FU traffic
    for (int c = 0; c < 600; c++) begin
      rst    = ($urandom_range(99) == 0);
      squash = ($urandom_range(24) == 0);
      for (int i = 0; i < N; i++) prio[i] = ($urandom_range(3) == 0);
      step();
      for (int i = 0; i < N; i++) begin
        if (rst || squash) begin
          done[i] = 1'b0;
        end else if (m_ack[i] || !done[i]) begin
          if ($urandom_range(99) < 60) begin
            done[i] = 1'b1; tag[i] = TW'($urandom); val[i] = $urandom;
          end else begin
            done[i] = 1'b0;
          end
        end
      end
    end
    rst = 1'b0; squash = 1'b0; done = '0;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
